// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per req/ack handshake
// and holds it for the decoder until it is consumed, then computes the next PC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [2:0]  pc_control,
  input  logic [31:0] reg_rs,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign_err,
  output logic        ctrl_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_misalign_err;
  logic        r_ctrl_err;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_off;
  logic [31:0] w_next_pc;
  logic        w_set_misalign;
  logic        w_set_ctrl;
  logic        w_capture;
  logic        w_consume;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: every output of a combinational block gets a default first; otherwise a latch is inferred.
  always_comb begin
    w_state_next = r_state;
    imem_req     = 1'b0;
    instr_valid  = 1'b0;
    case (r_state)
      S_IDLE:  w_state_next = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) w_state_next = S_HOLD;
      end
      S_HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) w_state_next = S_FETCH;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_capture  = (r_state == S_FETCH) && imem_ack;
  assign w_consume  = (r_state == S_HOLD) && instr_ready;
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

  always_comb begin
    w_next_pc      = w_pc_plus4;
    w_set_misalign = 1'b0;
    w_set_ctrl     = 1'b0;
    case (pc_control)
      3'b000: w_next_pc = w_pc_plus4;
      3'b001: w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
      3'b010: begin
        w_next_pc      = {reg_rs[31:2], 2'b00};
        w_set_misalign = |reg_rs[1:0];
      end
      3'b011: w_next_pc = w_pc_plus4 + w_br_off;
      // Reserved codes fall through sequentially and only flag the error.
      default: w_set_ctrl = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc           <= RESET_PC;
      r_instr        <= 32'h0;
      r_misalign_err <= 1'b0;
      r_ctrl_err     <= 1'b0;
    end else begin
      if (w_capture) r_instr <= imem_rdata;
      if (w_consume) begin
        r_pc           <= w_next_pc;
        r_misalign_err <= r_misalign_err | w_set_misalign;
        r_ctrl_err     <= r_ctrl_err | w_set_ctrl;
      end
    end
  end

  assign imem_addr    = r_pc;
  assign pc           = r_pc;
  assign pc_plus4     = w_pc_plus4;
  assign instr        = r_instr;
  assign misalign_err = r_misalign_err;
  assign ctrl_err     = r_ctrl_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed control-flow table, randomized instruction stream
// against a transaction-level PC model, and a reset-during-fetch sequence.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  pc_control;
  logic [31:0] reg_rs;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;
  logic        ctrl_err;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_control(pc_control), .reg_rs(reg_rs),
    .pc(pc), .pc_plus4(pc_plus4),
    .misalign_err(misalign_err), .ctrl_err(ctrl_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level model: the PC of the next instruction and the sticky flags.
  logic [31:0] m_pc;
  logic        m_mis;
  logic        m_ctrl;

  typedef struct {
    logic [31:0] word;
    int          wait_n;
    int          stall_n;
    logic [2:0]  ctl;
    logic [31:0] rs;
    logic [31:0] exp_next;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Next PC from the architectural rules, using plain arithmetic on the word.
  function automatic logic [31:0] model_next(input logic [31:0] pc_v, input logic [31:0] word,
                                             input logic [2:0] ctl, input logic [31:0] rs,
                                             output logic mis, output logic cerr);
    logic [31:0] p4;
    logic [31:0] res;
    int          off;
    p4   = pc_v + 32'd4;
    res  = p4;
    mis  = 1'b0;
    cerr = 1'b0;
    if (ctl >= 3'd4) cerr = 1'b1;
    else if (ctl == 3'd1) res = (p4 & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
    else if (ctl == 3'd2) begin
      mis = (rs % 4) != 0;
      res = rs - (rs % 4);
    end else if (ctl == 3'd3) begin
      off = int'($signed(word[15:0])) * 4;
      res = p4 + 32'(off);
    end
    return res;
  endfunction

  // One complete fetch/hold/consume transaction, starting at a falling edge.
  task automatic do_instr(input logic [31:0] word, input int wait_n, input int stall_n,
                          input logic [2:0] ctl, input logic [31:0] rs,
                          input logic use_exp, input logic [31:0] exp_next, input logic tight);
    int          polls;
    logic [31:0] nxt;
    logic        mis;
    logic        cerr;
    polls = 0;
    while (!imem_req && polls < 20) begin
      @(negedge clk);
      polls++;
    end
    if (!imem_req) begin
      check("req_timeout", 32'(imem_req), 32'd1);
      return;
    end
    if (tight) check("no_bubble", 32'(polls), 32'd0);
    check("fetch_addr", imem_addr, m_pc);
    for (int w = 0; w < wait_n; w++) begin
      imem_ack    = 1'b0;
      instr_ready = 1'($urandom % 2);
      pc_control  = 3'($urandom);
      reg_rs      = $urandom;
      @(negedge clk);
      check("wait_req", 32'(imem_req), 32'd1);
      check("wait_addr", imem_addr, m_pc);
      check("wait_valid", 32'(instr_valid), 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check("hold_valid", 32'(instr_valid), 32'd1);
    check("hold_instr", instr, word);
    check("hold_pc", pc, m_pc);
    check("hold_pc_plus4", pc_plus4, m_pc + 32'd4);
    check("hold_req", 32'(imem_req), 32'd0);
    for (int s = 0; s < stall_n; s++) begin
      instr_ready = 1'b0;
      pc_control  = 3'($urandom);
      reg_rs      = $urandom;
      imem_ack    = 1'($urandom % 2);
      imem_rdata  = $urandom;
      @(negedge clk);
      check("stall_instr", instr, word);
      check("stall_pc", pc, m_pc);
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_req", 32'(imem_req), 32'd0);
      check("stall_errs", {30'd0, misalign_err, ctrl_err}, {30'd0, m_mis, m_ctrl});
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    pc_control  = ctl;
    reg_rs      = rs;
    @(negedge clk);
    instr_ready = 1'b0;
    pc_control  = 3'($urandom);
    reg_rs      = $urandom;
    nxt    = model_next(m_pc, word, ctl, rs, mis, cerr);
    m_mis  = m_mis | mis;
    m_ctrl = m_ctrl | cerr;
    if (use_exp) check("next_pc_table", imem_addr, exp_next);
    else         check("next_pc_model", imem_addr, nxt);
    m_pc = nxt;
    check("after_valid", 32'(instr_valid), 32'd0);
    check("after_req", 32'(imem_req), 32'd1);
    check("misalign_err", 32'(misalign_err), 32'(m_mis));
    check("ctrl_err", 32'(ctrl_err), 32'(m_ctrl));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{32'h2408_0005, 0, 0, 3'b000, 32'h0,         32'h0000_0004};
    tbl[1]  = '{32'h2408_0005, 0, 0, 3'b000, 32'h0,         32'h0000_0008};
    tbl[2]  = '{32'h2408_0005, 3, 5, 3'b000, 32'h0,         32'h0000_000C};
    tbl[3]  = '{32'h0C10_0004, 0, 0, 3'b001, 32'h0,         32'h0040_0010};
    tbl[4]  = '{32'h1000_FFFE, 1, 2, 3'b011, 32'h0,         32'h0040_000C};
    tbl[5]  = '{32'h0000_0000, 0, 0, 3'b000, 32'h0,         32'h0040_0010};
    tbl[6]  = '{32'h0810_0000, 0, 1, 3'b001, 32'h0,         32'h0040_0000};
    tbl[7]  = '{32'h0080_0008, 0, 0, 3'b010, 32'h0000_1003, 32'h0000_1000};
    tbl[8]  = '{32'hFC00_0000, 2, 0, 3'b101, 32'h0,         32'h0000_1004};
    tbl[9]  = '{32'h0080_0008, 0, 0, 3'b010, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    tbl[10] = '{32'h2408_0005, 0, 0, 3'b000, 32'h0,         32'h0000_0000};

    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    pc_control  = 3'b000;
    reg_rs      = 32'h0;
    m_pc   = RESET_PC;
    m_mis  = 1'b0;
    m_ctrl = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_pc", pc, RESET_PC);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);
    check("rst_instr", instr, 32'h0);
    check("rst_ctl", {28'd0, imem_req, instr_valid, misalign_err, ctrl_err}, 32'd0);

    rst_n = 1'b1;
    #1;
    check("idle_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    check("idle_one_cycle", 32'(imem_req), 32'd1);

    for (int i = 0; i < 11; i++)
      do_instr(tbl[i].word, tbl[i].wait_n, tbl[i].stall_n, tbl[i].ctl, tbl[i].rs,
               1'b1, tbl[i].exp_next, 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] ctl;
      ctl = ($urandom % 5 == 0) ? 3'($urandom % 8) : 3'($urandom % 4);
      do_instr($urandom, int'($urandom % 4), int'($urandom % 4), ctl, $urandom,
               1'b0, 32'h0, 1'b1);
    end

    // Reset in the middle of a pending fetch, then a stale ack during IDLE.
    imem_ack = 1'b0;
    @(negedge clk);
    check("pre_rst_req", 32'(imem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(imem_req), 32'd0);
    check("midrst_pc", pc, RESET_PC);
    check("midrst_instr", instr, 32'h0);
    check("midrst_flags", {29'd0, instr_valid, misalign_err, ctrl_err}, 32'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    check("late_ack_idle_req", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1 imem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_instr", instr, 32'h0);
    check("late_ack_valid", 32'(instr_valid), 32'd0);
    check("restart_req", 32'(imem_req), 32'd1);
    check("restart_addr", imem_addr, RESET_PC);
    m_pc   = RESET_PC;
    m_mis  = 1'b0;
    m_ctrl = 1'b0;
    do_instr(32'h2408_0005, 0, 0, 3'b000, 32'h0, 1'b1, RESET_PC + 32'd4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction decoder.
- Owns the program counter and fetches one word at a time from instruction memory over a req/ack handshake.
- Holds the fetched instruction stable for the decoder and accepts the decoder's 3-bit pc_control to compute the next PC (sequential, jump, jump-register, taken branch).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  instruction memory read request.
- imem_addr  out  32  instruction memory word address (byte address, bits[1:0]=0).
- imem_ack  in  1  memory response valid; imem_rdata is sampled in the same cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  registered instruction presented to the decoder.
- instr_valid  out  1  instr holds a valid fetched word.
- instr_ready  in  1  decoder/execute consumes instr this cycle; pc_control and reg_rs are valid when this is high.
- pc_control  in  3  000 seq, 001 J/JAL, 010 JR/JALR, 011 taken branch; 1xx reserved.
- reg_rs  in  32  register-file rs value (JR/JALR target).
- pc  out  32  address of the instruction in instr.
- pc_plus4  out  32  pc+4 (link value for JAL/JALR).
- misalign_err  out  1  sticky: a JR target had bits[1:0]!=0.
- ctrl_err  out  1  sticky: a reserved pc_control code was consumed.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, instr=32'h0, instr_valid=0, imem_req=0, imem_addr=RESET_PC, misalign_err=0, ctrl_err=0.
- Reset mid-fetch abandons the transaction. An imem_ack arriving outside FETCH is ignored.
- pc_plus4 = pc + 4, mod 2^32. Wrap-around is legal: 32'hFFFF_FFFC -> 32'h0.
- FSM states: IDLE, FETCH, HOLD.
- IDLE: one cycle after reset release, then go to FETCH. Outputs keep their reset values.
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until imem_ack.
  - On imem_ack: instr<=imem_rdata, instr_valid<=1, go to HOLD. imem_req drops in the next cycle.
  - If no ack, stay in FETCH indefinitely.
- HOLD:
  - instr_valid=1, imem_req=0; instr and pc are stable.
  - instr_ready=0: stay in HOLD.
  - instr_ready=1: pc<=next_pc, instr_valid<=0, go to FETCH.
- next_pc by pc_control:
  - 000: pc_plus4.
  - 001: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - 010: {reg_rs[31:2], 2'b00}; if reg_rs[1:0]!=0, also set misalign_err.
  - 011: pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}, mod 2^32.
  - 1xx: pc_plus4, and set ctrl_err.
- No branch delay slot.
- pc_control and reg_rs are sampled only on the cycle where instr_valid & instr_ready; ignored otherwise.
- Latency:
  - Ack in the first FETCH cycle gives instr_valid in the next cycle.
  - Peak throughput is one instruction per 2 cycles (FETCH, HOLD), with zero-wait memory and instr_ready held high.
  - Each memory wait cycle adds one cycle.
- Sticky error flags clear only on reset. They never block fetching.
- instr_ready asserted while instr_valid=0 has no effect.

Test Plan:
- Reset release, memory acks in the same cycle with 32'h2408_0005, instr_ready=1, pc_control=000 -> imem_addr 0,4,8 on successive FETCH cycles; instr_valid pulses every 2nd cycle; pc_plus4=4 while pc=0.
- Memory wait: ack delayed 3 cycles -> imem_req high and imem_addr stable for 4 cycles; instr captured on the ack cycle only; instr_valid one cycle later.
- Backpressure: instr_ready=0 for 5 cycles in HOLD -> instr/pc stable, no imem_req; pc_control toggling during stall has no effect.
- Control flow:
  - pc=32'h0040_0010, instr=32'h0810_0000, pc_control=001 -> next fetch at 32'h0040_0000.
  - BEQ, instr[15:0]=16'hFFFE, pc_control=011 -> next fetch at 32'h0040_000C.
- JR with reg_rs=32'h0000_1003, pc_control=010 -> next fetch 32'h0000_1000, misalign_err=1 and stays 1; pc_control=3'b101 -> next fetch pc+4, ctrl_err=1.
- Wrap-around and reset:
  - pc=32'hFFFF_FFFC, sequential -> next fetch 32'h0.
  - rst_n low mid-FETCH, then a late ack after release -> ack ignored; restart at RESET_PC after the IDLE cycle.
